// File: rtl/dm_responder_if.sv
// Request/response bundle between the CPU controller (master) and the data-memory responder (slave).
interface dm_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  enable_memaccess;
  logic                  DM_read;
  logic                  DM_write;
  logic [ADDR_WIDTH-1:0] DM_address;
  logic [DATA_WIDTH-1:0] DM_in;
  logic [DATA_WIDTH-1:0] DM_out;
  logic                  DM_ready;
  logic                  DM_error;
  logic                  DM_busy;

  modport master (
    output enable_memaccess, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, DM_ready, DM_error, DM_busy
  );

  modport slave (
    input  enable_memaccess, DM_read, DM_write, DM_address, DM_in,
    output DM_out, DM_ready, DM_error, DM_busy
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store in IDLE, waits WAIT_STATES cycles,
// performs the array access on entry to RESP and pulses DM_ready (with DM_error on illegal requests).
module dm_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 2
) (
  input  logic          clock,
  input  logic          reset,
  dm_responder_if.slave bus
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  enter_resp;
  logic                  live_err;

  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] din_p0;
  logic                  read_p0;
  logic                  err_p0;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_din;
  logic                  acc_read;
  logic                  acc_err;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    accept   = (state == S_IDLE) && bus.enable_memaccess && (bus.DM_read || bus.DM_write);
    live_err = (bus.DM_read && bus.DM_write) || (int'(bus.DM_address) >= DEPTH);

    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  state_nxt = (cnt == 4'd0) ? S_RESP : S_WAIT;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

    // With zero wait states the access shares the acceptance edge, so it must use the live request.
    if (state == S_IDLE) begin
      acc_addr = bus.DM_address;
      acc_din  = bus.DM_in;
      acc_read = bus.DM_read && !bus.DM_write;
      acc_err  = live_err;
    end else begin
      acc_addr = addr_p0;
      acc_din  = din_p0;
      acc_read = read_p0;
      acc_err  = err_p0;
    end
    idx = acc_addr[IDX_W-1:0];
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0 <= bus.DM_address;
      din_p0  <= bus.DM_in;
      read_p0 <= bus.DM_read && !bus.DM_write;
      err_p0  <= live_err;
    end
  end

  // Array write on entry to RESP; reset on that same edge discards the pending store.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && !acc_err && !acc_read) mem[idx] <= acc_din;
  end

  // Stage p1: control state and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      bus.DM_out   <= '0;
      bus.DM_ready <= 1'b0;
      bus.DM_error <= 1'b0;
      bus.DM_busy  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.DM_ready <= enter_resp;
      bus.DM_error <= enter_resp && acc_err;
      bus.DM_busy  <= (state_nxt != S_IDLE);
      if (accept) cnt <= WAIT_LOAD;
      else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        if (acc_err)       bus.DM_out <= '0;
        else if (acc_read) bus.DM_out <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed check of two responder configurations against a transaction-level model.
module tb_dm_responder;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dm_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  dm_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(1024), .WAIT_STATES(2)) u0 (
    .clock(clock), .reset(reset), .bus(bus0));
  dm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096), .WAIT_STATES(0)) u1 (
    .clock(clock), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          ws    [2] = '{2, 0};
  int          depth [2] = '{1024, 4096};
  logic [31:0] mmem  [2][4096];
  bit          mknown[2][4096];
  bit          pend  [2];
  int          acc_e [2];
  bit          p_rd  [2];
  bit          p_err [2];
  logic [11:0] p_addr[2];
  logic [31:0] p_din [2];
  bit          e_rdy [2];
  bit          e_err [2];
  bit          e_busy[2];
  logic [31:0] e_out [2];
  bit          e_known[2];
  int          cyc = 0;

  always @(posedge clock) begin
    bit en, rd, wr;
    logic [11:0] ad;
    logic [31:0] dn;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      en = (i == 0) ? bus0.enable_memaccess : bus1.enable_memaccess;
      rd = (i == 0) ? bus0.DM_read    : bus1.DM_read;
      wr = (i == 0) ? bus0.DM_write   : bus1.DM_write;
      ad = (i == 0) ? bus0.DM_address : bus1.DM_address;
      dn = (i == 0) ? bus0.DM_in      : bus1.DM_in;
      if (reset) begin
        pend[i] = 0; e_rdy[i] = 0; e_err[i] = 0; e_busy[i] = 0;
        e_out[i] = '0; e_known[i] = 1;
      end else begin
        e_rdy[i] = 0; e_err[i] = 0;
        // Idle again two edges after the response edge (the RESP cycle itself ignores requests).
        if ((!pend[i] || cyc >= acc_e[i] + ws[i] + 2) && en && (rd || wr)) begin
          pend[i] = 1; acc_e[i] = cyc; p_rd[i] = rd && !wr;
          p_err[i] = (rd && wr) || (int'(ad) >= depth[i]);
          p_addr[i] = ad; p_din[i] = dn;
        end
        if (pend[i] && cyc == acc_e[i] + ws[i]) begin
          e_rdy[i] = 1; e_err[i] = p_err[i];
          if (p_err[i]) begin
            e_out[i] = '0; e_known[i] = 1;
          end else if (p_rd[i]) begin
            e_out[i] = mmem[i][p_addr[i]]; e_known[i] = mknown[i][p_addr[i]];
          end else begin
            mmem[i][p_addr[i]] = p_din[i]; mknown[i][p_addr[i]] = 1;
          end
        end
        e_busy[i] = pend[i] && (cyc <= acc_e[i] + ws[i]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.ready", i), 32'((i == 0) ? bus0.DM_ready : bus1.DM_ready), 32'(e_rdy[i]));
        chk($sformatf("u%0d.error", i), 32'((i == 0) ? bus0.DM_error : bus1.DM_error), 32'(e_err[i]));
        chk($sformatf("u%0d.busy", i),  32'((i == 0) ? bus0.DM_busy  : bus1.DM_busy),  32'(e_busy[i]));
        if (e_known[i])
          chk($sformatf("u%0d.out", i), (i == 0) ? bus0.DM_out : bus1.DM_out, e_out[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input int i, input bit en, input bit rd, input bit wr,
                     input logic [11:0] ad, input logic [31:0] dn);
    if (i == 0) begin
      bus0.enable_memaccess = en; bus0.DM_read = rd; bus0.DM_write = wr;
      bus0.DM_address = ad; bus0.DM_in = dn;
    end else begin
      bus1.enable_memaccess = en; bus1.DM_read = rd; bus1.DM_write = wr;
      bus1.DM_address = ad; bus1.DM_in = dn;
    end
  endtask

  // One transaction on u0 (two wait states); called right after a negedge.
  task automatic txn0(input bit rd, input bit wr, input logic [11:0] ad, input logic [31:0] dn,
                      input bit scramble, output logic [31:0] out, output bit rdy, output bit err);
    bit early;
    drv(0, 1, rd, wr, ad, dn);
    @(negedge clock);
    early = bus0.DM_ready;
    if (scramble) drv(0, 0, !rd, rd, ad ^ 12'h003, ~dn);
    else          drv(0, 0, 0, 0, '0, '0);
    @(negedge clock);
    early |= bus0.DM_ready;
    @(negedge clock);
    rdy = bus0.DM_ready && !early;
    out = bus0.DM_out;
    err = bus0.DM_error;
    @(negedge clock);
    rdy = rdy && !bus0.DM_ready;
  endtask

  initial begin
    logic [31:0] out;
    bit rdy, err;
    bit noresp;
    int r;
    logic [11:0] ad;

    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst.u0.ready", 32'(bus0.DM_ready), 32'd0);
    chk("rst.u0.busy",  32'(bus0.DM_busy),  32'd0);
    chk("rst.u0.out",   bus0.DM_out,        32'd0);
    chk("rst.u1.error", 32'(bus1.DM_error), 32'd0);
    chk("rst.u1.out",   bus1.DM_out,        32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Write then read back with two wait states.
    txn0(0, 1, 12'd5, 32'hDEADBEEF, 0, out, rdy, err);
    chk("t1.wr.ready_at_T+3", 32'(rdy), 32'd1);
    chk("t1.wr.error", 32'(err), 32'd0);
    txn0(1, 0, 12'd5, '0, 0, out, rdy, err);
    chk("t1.rd.ready_at_T+3", 32'(rdy), 32'd1);
    chk("t1.rd.data", out, 32'hDEADBEEF);

    // Out-of-range accesses on the 1024-word instance.
    txn0(1, 0, 12'd1024, '0, 0, out, rdy, err);
    chk("t3.oor.ready", 32'(rdy), 32'd1);
    chk("t3.oor.error", 32'(err), 32'd1);
    chk("t3.oor.out",   out,      32'd0);
    txn0(0, 1, 12'd976, 32'hA5A50976, 0, out, rdy, err);
    txn0(0, 1, 12'd2000, 32'h0BAD0BAD, 0, out, rdy, err);
    chk("t3.oorwr.error", 32'(err), 32'd1);
    txn0(1, 0, 12'd976, '0, 0, out, rdy, err);
    chk("t3.alias.data", out, 32'hA5A50976);

    // Read and write together; then a request without enable.
    txn0(1, 1, 12'd5, 32'h12345678, 0, out, rdy, err);
    chk("t4.rw.ready", 32'(rdy), 32'd1);
    chk("t4.rw.error", 32'(err), 32'd1);
    txn0(1, 0, 12'd5, '0, 0, out, rdy, err);
    chk("t4.rw.nowrite", out, 32'hDEADBEEF);
    drv(0, 0, 1, 0, 12'd5, '0);
    noresp = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (bus0.DM_ready || bus0.DM_busy) noresp = 1'b0;
    end
    chk("t4.noenable.silent", 32'(noresp), 32'd1);
    drv(0, 0, 0, 0, '0, '0);
    @(negedge clock);

    // Inputs changed during WAIT must not matter.
    txn0(0, 1, 12'd9, 32'h0BADF00D, 1, out, rdy, err);
    txn0(1, 0, 12'd9, '0, 1, out, rdy, err);
    chk("t5.captured.data", out, 32'h0BADF00D);

    // Reset during the wait of a store.
    txn0(0, 1, 12'd7, 32'h00000011, 0, out, rdy, err);
    drv(0, 1, 0, 1, 12'd7, 32'h00000022);
    @(negedge clock);
    drv(0, 0, 0, 0, '0, '0);
    reset = 1'b1;
    @(negedge clock);
    chk("t6.busy_after_reset", 32'(bus0.DM_busy), 32'd0);
    reset = 1'b0;
    noresp = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (bus0.DM_ready) noresp = 1'b0;
    end
    chk("t6.no_ready", 32'(noresp), 32'd1);
    txn0(1, 0, 12'd7, '0, 0, out, rdy, err);
    chk("t6.store_dropped", out, 32'h00000011);

    // Zero wait states on u1: held request gives ready pattern 1,0,1.
    drv(1, 1, 0, 1, 12'd3, 32'h600D0003);
    @(negedge clock);
    chk("t2.wr.ready_T+1", 32'(bus1.DM_ready), 32'd1);
    drv(1, 0, 0, 0, '0, '0);
    @(negedge clock);
    drv(1, 1, 1, 0, 12'd3, '0);
    @(negedge clock);
    chk("t2.rd.ready_T+1", 32'(bus1.DM_ready), 32'd1);
    chk("t2.rd.data", bus1.DM_out, 32'h600D0003);
    @(negedge clock);
    chk("t2.resp_ignored", 32'(bus1.DM_ready), 32'd0);
    @(negedge clock);
    chk("t2.reaccept_T+2", 32'(bus1.DM_ready), 32'd1);
    drv(1, 0, 0, 0, '0, '0);
    repeat (2) @(negedge clock);

    // Randomized traffic on both instances, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16)       ad = 12'(r);
        else if (r == 16) ad = 12'd1023;
        else if (r == 17) ad = 12'(1024 + $urandom_range(0, 50));
        else if (r == 18) ad = 12'd4095;
        else              ad = 12'($urandom_range(0, 4095));
        r = $urandom_range(0, 9);
        drv(i, $urandom_range(0, 9) != 0, (r < 5) || (r == 9), r >= 5, ad, $urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
    repeat (6) @(negedge clock);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
